// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
// Shared constants and types for the multiply/divide sequencer.
//   - FUN_* : 6-bit function codes, the same codes the decoder generates for the ALU
//   - state_e : controller FSM states (IDLE, CALC, FIX)
//   - mode_e  : datapath mode for the single-iteration step
//   - is_muldiv() : true for the four iterative operations
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

  localparam logic [5:0] FUN_MTHI  = 6'h11;
  localparam logic [5:0] FUN_MTLO  = 6'h13;
  localparam logic [5:0] FUN_MULT  = 6'h18;
  localparam logic [5:0] FUN_MULTU = 6'h19;
  localparam logic [5:0] FUN_DIV   = 6'h1A;
  localparam logic [5:0] FUN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FUN_MULT) || (f == FUN_MULTU) || (f == FUN_DIV) || (f == FUN_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_if
// EX-stage request bus of the multiply/divide unit plus its HI/LO results.
//   start, funct, opA, opB, cancel : issued by the pipeline (master)
//   busy, hi, lo, state            : returned by the unit (slave)
//
// Handshake: start is a one-cycle request qualifier, sampled on the rising
// edge. It is accepted only when busy=0 and cancel=0 in that cycle. busy=1
// means HI/LO are not valid and no new request may be issued; a start seen
// while busy=1 is dropped. There is no per-request acknowledge: acceptance
// is implied by busy rising on the next cycle (mul/div) or by HI/LO updating
// (MTHI/MTLO).
// -----------------------------------------------------------------------------
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  import muldiv_ctrl_pkg::*;

  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  state_e           state;   // registered FSM state, for observation only

  modport master (
    output start, funct, opA, opB, cancel,
    input  busy, hi, lo, state
  );

  modport slave (
    input  start, funct, opA, opB, cancel,
    output busy, hi, lo, state
  );

endinterface

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// Combinational single iteration of the multiply/divide datapath.
//   mode            : MODE_MUL (shift-add) or MODE_DIV (restoring division)
//   acc_hi, acc_lo  : working pair; product {hi,lo} or {rem,quot}
//   operand         : multiplicand (mul) or divisor (div), both magnitudes
//   next_hi,next_lo : working pair after this iteration
// -----------------------------------------------------------------------------
module muldiv_step
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mode_e            mode,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted_rem;
  logic [WIDTH:0] trial;

  always_comb begin
    // Multiply: the multiplier lives in acc_lo and is consumed LSB first;
    // the carry out of the add becomes the new top bit after the shift.
    sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);

    // Divide: the remainder stays below the divisor, so the shifted value
    // fits in WIDTH+1 bits and trial[WIDTH] is the borrow (negative) flag.
    // With a zero divisor the remainder holds at most WIDTH-1 dividend bits
    // before the last shift, so the borrow stays clear and the quotient
    // fills with ones while the remainder collects the dividend.
    shifted_rem = {acc_hi, acc_lo[WIDTH-1]};
    trial       = shifted_rem - {1'b0, operand};

    next_hi = acc_hi;
    next_lo = acc_lo;
    if (mode == MODE_MUL) begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      next_hi = trial[WIDTH-1:0];
      next_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      next_hi = shifted_rem[WIDTH-1:0];
      next_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Sequencer for the iterative multiply/divide resource and the HI/LO pair.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : muldiv_ctrl_if.slave (start/funct/opA/opB/cancel in,
//           busy/hi/lo/state out)
// A mul/div accepted at edge E keeps busy high for WIDTH+1 cycles
// (WIDTH CALC iterations + one FIX cycle); HI/LO update at the FIX edge.
// MTHI/MTLO write HI/LO at the accepting edge without going busy.
// -----------------------------------------------------------------------------
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic          clk,
  input logic          reset,
  muldiv_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  mode_e              mode_q;
  logic               neg_q_q;   // negate product / quotient at FIX
  logic               neg_r_q;   // negate remainder at FIX
  logic [WIDTH-1:0]   opnd_q;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   w_hi_q, w_lo_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               idle_take;
  logic               signed_op;
  logic               div_op;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // cancel in IDLE suppresses every request, including MTHI/MTLO
  assign idle_take = (state_q == ST_IDLE) && bus.start && !bus.cancel;
  assign signed_op = (bus.funct == FUN_MULT) || (bus.funct == FUN_DIV);
  assign div_op    = (bus.funct == FUN_DIV)  || (bus.funct == FUN_DIVU);
  assign abs_a     = (signed_op && bus.opA[WIDTH-1]) ? -bus.opA : bus.opA;
  assign abs_b     = (signed_op && bus.opB[WIDTH-1]) ? -bus.opB : bus.opB;

  assign prod_fix  = neg_q_q ? -{w_hi_q, w_lo_q} : {w_hi_q, w_lo_q};
  assign quot_fix  = neg_q_q ? -w_lo_q : w_lo_q;
  assign rem_fix   = neg_r_q ? -w_hi_q : w_hi_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode    (mode_q),
    .acc_hi  (w_hi_q),
    .acc_lo  (w_lo_q),
    .operand (opnd_q),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (idle_take && is_muldiv(bus.funct)) state_d = ST_CALC;
      ST_CALC: begin
        if (bus.cancel)               state_d = ST_IDLE;
        else if (count_q == '0)       state_d = ST_FIX;
      end
      ST_FIX:                         state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      mode_q  <= MODE_MUL;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      opnd_q  <= '0;
      w_hi_q  <= '0;
      w_lo_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (idle_take) begin
            if (bus.funct == FUN_MTHI) hi_q <= bus.opA;
            if (bus.funct == FUN_MTLO) lo_q <= bus.opA;
            if (is_muldiv(bus.funct)) begin
              count_q <= CNT_W'(WIDTH - 1);
              mode_q  <= div_op ? MODE_DIV : MODE_MUL;
              // A zero divisor must yield an all-ones quotient regardless
              // of the dividend sign, so it never requests negation.
              neg_q_q <= signed_op && (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1])
                         && (bus.opB != '0);
              neg_r_q <= signed_op && bus.opA[WIDTH-1];
              w_hi_q  <= '0;
              w_lo_q  <= div_op ? abs_a : abs_b;
              opnd_q  <= div_op ? abs_b : abs_a;
            end
          end
        end
        ST_CALC: begin
          w_hi_q  <= step_hi;
          w_lo_q  <= step_lo;
          count_q <= count_q - CNT_W'(1);
        end
        ST_FIX: begin
          if (!bus.cancel) begin
            if (mode_q == MODE_MUL) begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end else begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.state = state_q;

  // Hazard logic must hold off new requests while busy; flag any that leak.
  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (reset) !(bus.busy && bus.start)
  ) else $warning("muldiv_ctrl: start while busy dropped");

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the iterative multiply/divide resource and its HI/LO registers.
- Sits beside the ALU in the EX stage and is driven by the same 6-bit function code that is generated for the ALU.
- Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO. Runs multiply/divide over 32 iteration cycles with one sign-fix cycle.
- Exposes `busy`, so hazard logic stalls MFHI/MFLO and any new mul/div until HI/LO are valid.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; the counter covers WIDTH-1 down to 0.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  EX-stage instruction valid and targeting this unit
- funct  input  6  function code: `FUN_MULT, `FUN_MULTU, `FUN_DIV, `FUN_DIVU, `FUN_MTHI, `FUN_MTLO
- opA  input  WIDTH  rs value (dividend / multiplicand / MTHI, MTLO source)
- opB  input  WIDTH  rt value (divisor / multiplier)
- cancel  input  1  exception flush; abort the in-flight operation
- busy  output  1  operation in flight; HI/LO not yet valid
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset, asynchronous while reset=1:
  - state=IDLE, busy=0, hi=0, lo=0.
  - Counter and working registers cleared.
  - Reset mid-operation discards the operation, and HI/LO read 0 afterwards.
- States are IDLE, CALC and FIX. busy = (state != IDLE), decoded from registered state only.
- IDLE with start=1:
  - MTHI: hi <= opA at this edge; stay in IDLE. lo unchanged.
  - MTLO: lo <= opA at this edge; stay in IDLE. hi unchanged.
  - MULT/MULTU/DIV/DIVU: latch operands and move to CALC with count=WIDTH-1.
    - Signed ops latch |opA| and |opB|.
    - Signed ops record neg_q = sign(opA)^sign(opB) and neg_r = sign(opA).
    - Unsigned ops clear both flags.
  - Any other funct: ignored, no state change.
- CALC, one iteration per cycle:
  - Multiply is shift-add on a 2*WIDTH product: add the multiplicand when the multiplier LSB is 1, then shift right.
  - Divide is restoring division on a {rem, quot} pair. Each step shifts left 1 and subtracts the divisor. A non-negative result commits and sets the quotient bit to 1; otherwise the result is restored and the bit is 0.
  - Leave CALC for FIX after the count=0 iteration.
- FIX, one cycle:
  - Apply sign correction: negate the product if neg_q; negate the quotient if neg_q and the remainder if neg_r.
  - Write hi/lo at the FIX edge, then go to IDLE.
  - Multiply: hi = product[63:32], lo = product[31:0]. Divide: hi = remainder, lo = quotient.
- Latency: accept at edge E, then busy=1 for exactly WIDTH+1 = 33 cycles. hi/lo carry the new values in the first cycle where busy=0.
- Divide by zero: no trap. hi = opA (original, signed value), lo = all ones. The full 33-cycle latency still applies.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. This wrap is natural with the magnitude algorithm and requires no special case.
- start while busy is ignored and the operation is not restarted; hazard logic must guarantee this never happens. An assertion flags it in simulation.
- cancel:
  - When 1 in CALC or FIX, return to IDLE at the next edge. hi/lo keep their pre-operation values.
  - cancel in IDLE has no effect.
  - cancel and start in the same IDLE cycle: cancel wins and nothing is accepted, including MTHI/MTLO.
- hi and lo are registers with no combinational path from any input.

Decomposition:
- Function codes stay in the shared ISA constants header, which gains `FUN_MULT/MULTU/DIV/DIVU/MTHI/MTLO if absent.
- State encodings are local parameters of this block.
- One sub-module, muldiv_step: combinational single-iteration datapath that takes mode, working registers and operand and returns the next working registers.
- The controller keeps the FSM, counter, sign flags and HI/LO.

Test Plan:
1. MULTU opA=0xFFFFFFFF, opB=2 -> busy=1 for 33 cycles, then hi=0x00000001, lo=0xFFFFFFFE.
2. MULT opA=-3, opB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV opA=-7, opB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU opA=100, opB=0 -> after 33 cycles hi=100, lo=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTHI opA=0x1234, then MTLO opA=0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678 one edge after each, busy never asserts.
5. MULTU 5*6 with prior hi=0xAA, lo=0xBB; cancel at iteration 10 -> busy drops next edge, hi=0xAA, lo=0xBB. An immediate new MULTU 5*6 then gives lo=30.
6. reset asserted mid-CALC, asynchronously between edges -> busy=0, hi=lo=0 immediately. start during busy -> ignored and the original result is unchanged.
